fact_job_sequencer: RTL and testbench

- Bus-master controller that runs one factorial job at a time on the memory-mapped factorial core.
- Core register map: opstart 0x7000, opclear 0x7008, opdone 0x7010, intrEn 0x7018, operand 0x7020, result_h 0x7028, result_l 0x7030.
- Takes a job (operand, destination address), requests the shared bus, programs and starts the core, waits for completion, reads the 128-bit result, stores it to data memory, then clears the core.
- Sits beside the external master on the Top bus and replaces manual software sequencing.

---
 rtl/fact_job_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fact_job_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fact_job_sequencer.sv
// fact_job_sequencer: bus master that runs one factorial job on the memory-mapped core.
// Optional build macro FSEQ_POLL_EN: poll opdone instead of using the interrupt.
module fact_job_sequencer #(
  parameter logic [15:0] FACT_BASE  = 16'h7000,
  parameter logic [31:0] WAIT_LIMIT = 32'd20000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [63:0]  job_operand,
  input  logic [15:0]  job_dst,
  output logic         m_req,
  input  logic         m_grant,
  output logic         m_wr,
  output logic [15:0]  m_addr,
  output logic [63:0]  m_dout,
  input  logic [63:0]  m_din,
  input  logic         interrupt,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] result
);

  localparam logic [15:0] A_START = FACT_BASE + 16'h0000;
  localparam logic [15:0] A_CLEAR = FACT_BASE + 16'h0008;
  localparam logic [15:0] A_DONE  = FACT_BASE + 16'h0010;
  localparam logic [15:0] A_INTR  = FACT_BASE + 16'h0018;
  localparam logic [15:0] A_OPND  = FACT_BASE + 16'h0020;
  localparam logic [15:0] A_RESH  = FACT_BASE + 16'h0028;
  localparam logic [15:0] A_RESL  = FACT_BASE + 16'h0030;

`ifdef FSEQ_POLL_EN
  localparam logic [63:0] INTR_VAL = 64'd0;
`else
  localparam logic [63:0] INTR_VAL = 64'd1;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_OPND, S_INTR, S_START, S_WAIT, S_RDH,
    S_RDL, S_MEML, S_MEMH, S_CLR1, S_CLR0, S_DONE, S_ABORT
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    opnd_q, opnd_d;
  logic [15:0]    dst_q, dst_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           abort_q, abort_d;
  logic [63:0]    rh_q, rh_d;
  logic [127:0]   result_q, result_d;
  logic           wait_exit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opnd_q   <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      rh_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      rh_q     <= rh_d;
      result_q <= result_d;
    end
  end

`ifdef FSEQ_POLL_EN
  assign wait_exit = (cnt_q[2:0] == 3'd7) && m_din[0];
`else
  assign wait_exit = interrupt;
`endif

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    rh_d     = rh_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          opnd_d  = job_operand;
          dst_d   = job_dst & 16'hFFF8;
          abort_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ:   if (m_grant) state_d = S_OPND;
      S_OPND:  if (m_grant) state_d = S_INTR;
      S_INTR:  if (m_grant) state_d = S_START;
      S_START: begin
        if (m_grant) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_grant) begin
          cnt_d = cnt_q + 32'd1;
          if (wait_exit) begin
            state_d = S_RDH;
          end else if (cnt_q + 32'd1 >= WAIT_LIMIT) begin
            abort_d = 1'b1;
            state_d = S_CLR1;
          end
        end
      end
      S_RDH: begin
        if (m_grant) begin
          rh_d    = m_din;
          state_d = S_RDL;
        end
      end
      S_RDL: begin
        if (m_grant) begin
          result_d = {rh_q, m_din};
          state_d  = S_MEML;
        end
      end
      S_MEML:  if (m_grant) state_d = S_MEMH;
      S_MEMH:  if (m_grant) state_d = S_CLR1;
      S_CLR1:  if (m_grant) state_d = S_CLR0;
      S_CLR0:  if (m_grant) state_d = abort_q ? S_ABORT : S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus fields stay zero whenever grant is missing.
  always_comb begin
    job_ready = 1'b0;
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_addr    = '0;
    m_dout    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state_q)
      S_IDLE:  job_ready = 1'b1;
      S_DONE:  done = 1'b1;
      S_ABORT: error = 1'b1;
      default: begin
        m_req = 1'b1;
        busy  = 1'b1;
        if (m_grant) begin
          unique case (state_q)
            S_OPND:  begin m_wr = 1'b1; m_addr = A_OPND;  m_dout = opnd_q;   end
            S_INTR:  begin m_wr = 1'b1; m_addr = A_INTR;  m_dout = INTR_VAL; end
            S_START: begin m_wr = 1'b1; m_addr = A_START; m_dout = 64'd1;    end
            S_RDH:   m_addr = A_RESH;
            S_RDL:   m_addr = A_RESL;
            S_MEML:  begin m_wr = 1'b1; m_addr = dst_q;          m_dout = result_q[63:0];   end
            S_MEMH:  begin m_wr = 1'b1; m_addr = dst_q + 16'd8; m_dout = result_q[127:64]; end
            S_CLR1:  begin m_wr = 1'b1; m_addr = A_CLEAR; m_dout = 64'd1;    end
            S_CLR0:  begin m_wr = 1'b1; m_addr = A_CLEAR; m_dout = 64'd0;    end
`ifdef FSEQ_POLL_EN
            S_WAIT:  if (cnt_q[2:0] == 3'd7) m_addr = A_DONE;
`endif
            default: ;
          endcase
        end
      end
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_fact_job_sequencer.sv
// Bench for fact_job_sequencer: factorial-core/memory model plus a scoreboard of bus writes.
module tb_fact_job_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         job_valid;
  logic         job_ready;
  logic [63:0]  job_operand;
  logic [15:0]  job_dst;
  logic         m_req;
  logic         m_grant;
  logic         m_wr;
  logic [15:0]  m_addr;
  logic [63:0]  m_dout;
  logic [63:0]  m_din;
  logic         interrupt;
  logic         busy;
  logic         done;
  logic         error;
  logic [127:0] result;

  int ncmp = 0;
  int nerr = 0;

`ifdef FSEQ_POLL_EN
  localparam logic [63:0] IV = 64'd0;
`else
  localparam logic [63:0] IV = 64'd1;
`endif

  fact_job_sequencer #(.FACT_BASE(16'h7000), .WAIT_LIMIT(32'd50)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_operand(job_operand), .job_dst(job_dst),
    .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr),
    .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din),
    .interrupt(interrupt), .busy(busy), .done(done),
    .error(error), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r = 128'd1;
    for (longint i = 2; i <= longint'(n); i++) r = r * 128'(i);
    return r;
  endfunction

  // factorial core model; every captured write is logged
  logic [127:0] fres = '0;
  logic [63:0]  copnd = '0;
  logic         cdone = 1'b0;
  logic         ien = 1'b0;
  int           cdly = 0;
  bit           hang = 1'b0;
  logic [79:0]  wlog[$];
  logic [79:0]  expq[$];

  always @(posedge clk) begin
    if (cdly > 1) cdly <= cdly - 1;
    else if (cdly == 1) begin
      cdly <= 0;
      if (!hang) cdone <= 1'b1;
    end
    if (m_grant && m_wr) begin
      wlog.push_back({m_addr, m_dout});
      case (m_addr)
        16'h7020: copnd <= m_dout;
        16'h7018: ien <= m_dout[0];
        16'h7000: if (m_dout[0]) begin fres <= fact(copnd); cdly <= 6; end
        16'h7008: if (m_dout[0]) begin cdone <= 1'b0; cdly <= 0; end
        default: ;
      endcase
    end
  end

  assign interrupt = cdone & ien;

  always_comb begin
    m_din = '0;
    case (m_addr)
      16'h7028: m_din = fres[127:64];
      16'h7030: m_din = fres[63:0];
      16'h7010: m_din = {63'd0, cdone};
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_job(input logic [63:0] op, input logic [15:0] dst,
                            input bit ok);
    logic [127:0] r = fact(op);
    logic [15:0]  d = dst & 16'hFFF8;
    expq.push_back({16'h7020, op});
    expq.push_back({16'h7018, IV});
    expq.push_back({16'h7000, 64'd1});
    if (ok) begin
      expq.push_back({d, r[63:0]});
      expq.push_back({d + 16'd8, r[127:64]});
    end
    expq.push_back({16'h7008, 64'd1});
    expq.push_back({16'h7008, 64'd0});
  endtask

  task automatic offer(input logic [63:0] op, input logic [15:0] dst);
    @(negedge clk);
    job_operand = op;
    job_dst     = dst;
    job_valid   = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    check("busy_on", busy, 1);
    check("ready_off", job_ready, 0);
  endtask

  task automatic finish_job(input bit ok);
    bit seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done || error) begin seen = 1'b1; break; end
    end
    check("job_end", seen, 1);
    check("done_pulse", done, ok);
    check("error_pulse", error, !ok);
    check("busy_fall", busy, 0);
    @(negedge clk);
    check("pulse_clear", {done, error}, 0);
    check("ready_back", job_ready, 1);
    check("nwrites", wlog.size(), expq.size());
    while (wlog.size() > 0 && expq.size() > 0)
      check("bus_write", wlog.pop_front(), expq.pop_front());
    wlog.delete();
    expq.delete();
  endtask

  logic [127:0] last_res;

  initial begin
    reset = 1'b1;
    job_valid = 1'b0;
    job_operand = '0;
    job_dst = '0;
    m_grant = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", job_ready, 1);
    check("rst_req", m_req, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {done, error}, 0);
    check("rst_result", result, 0);
    reset = 1'b0;

    expect_job(64'd5, 16'h0070, 1'b1);
    offer(64'd5, 16'h0070);
    finish_job(1'b1);
    check("res5", result, 128'd120);

    expect_job(64'd20, 16'h00ff, 1'b1);
    offer(64'd20, 16'h00ff);
    finish_job(1'b1);
    check("res20", result, {64'd0, 64'h21C3677C82B40000});

    // grant withheld in REQ, then dropped for 3 cycles inside W_OPND
    expect_job(64'd7, 16'h0200, 1'b1);
    m_grant = 1'b0;
    offer(64'd7, 16'h0200);
    check("req_wait", m_req, 1);
    m_grant = 1'b1;
    @(negedge clk);
    m_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("gap_bus", {m_req, m_wr, m_addr}, {1'b1, 1'b0, 16'h0000});
      @(negedge clk);
    end
    check("gap_nowr", wlog.size(), 0);
    m_grant = 1'b1;
    finish_job(1'b1);
    check("res7", result, 128'd5040);

    last_res = result;
    hang = 1'b1;
    expect_job(64'd9, 16'h0300, 1'b0);
    offer(64'd9, 16'h0300);
    finish_job(1'b0);
    check("abort_res", result, last_res);

    offer(64'd4, 16'h0400);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_req", m_req, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", job_ready, 1);
    check("arst_result", result, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
